// File: rtl/cmd_credit_arbiter_if.sv
// Command-path interface for cmd_credit_arbiter.
// Carries the per-requester command buffers, the PSL response credit return
// and the registered command output toward the PSL.
//   req_valid_in/req_payload_in/req_ready_out : per-source pop handshake
//   response_valid_in/response_credits_in     : signed credit return
//   cmd_valid_out/cmd_payload_out/cmd_tag_out/cmd_src_out : issued command
// slave modport is the arbiter's view; master is the surrounding logic's view.
interface cmd_credit_arbiter_if #(
    parameter int unsigned NUM_REQ   = 5,
    parameter int unsigned PAYLOAD_W = 128
);
    logic [NUM_REQ-1:0]           req_valid_in;
    logic [NUM_REQ*PAYLOAD_W-1:0] req_payload_in;
    logic [NUM_REQ-1:0]           req_ready_out;
    logic                         response_valid_in;
    logic [8:0]                   response_credits_in;
    logic                         cmd_valid_out;
    logic [PAYLOAD_W-1:0]         cmd_payload_out;
    logic [7:0]                   cmd_tag_out;
    logic [2:0]                   cmd_src_out;

    modport slave (
        input  req_valid_in,
        input  req_payload_in,
        input  response_valid_in,
        input  response_credits_in,
        output req_ready_out,
        output cmd_valid_out,
        output cmd_payload_out,
        output cmd_tag_out,
        output cmd_src_out
    );

    modport master (
        output req_valid_in,
        output req_payload_in,
        output response_valid_in,
        output response_credits_in,
        input  req_ready_out,
        input  cmd_valid_out,
        input  cmd_payload_out,
        input  cmd_tag_out,
        input  cmd_src_out
    );
endinterface

// File: rtl/cmd_credit_arbiter.sv
// Round-robin PSL command arbiter with credit tracking.
// Shares the single PSL command port among WED, read, write, prefetch-read
// and prefetch-write sources. Credits load from room_in when the job starts
// and return through command responses; one command issues per cycle with a
// wrapping 8-bit tag.
// Ports:
//   clock, rstn_in  : clock and asynchronous active-low reset
//   enabled_in      : job running; rise loads credits, fall returns to IDLE
//   room_in         : PSL command room, sampled in LOAD
//   bus (slave)     : request handshake, response credits, command output
//   credits_out     : currently available credits
//   credit_overflow_error : sticky credit accounting error
module cmd_credit_arbiter #(
    parameter int unsigned NUM_REQ   = 5,
    parameter int unsigned PAYLOAD_W = 128,
    parameter int unsigned CREDIT_W  = 8
) (
    input  logic                clock,
    input  logic                rstn_in,
    input  logic                enabled_in,
    input  logic [CREDIT_W-1:0] room_in,
    cmd_credit_arbiter_if.slave bus,
    output logic [CREDIT_W-1:0] credits_out,
    output logic                credit_overflow_error
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SUM_W = CREDIT_W + 2;
    localparam int unsigned TAG_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [CREDIT_W-1:0]       credits;
    logic [CREDIT_W-1:0]       room_q;
    logic [IDX_W-1:0]          rr_ptr;
    logic [TAG_W-1:0]          tag;

    logic                      grant;
    logic [IDX_W-1:0]          grant_idx;
    logic [NUM_REQ-1:0]        ready;
    logic signed [SUM_W-1:0]   ret;
    logic signed [SUM_W-1:0]   next_credits;
    logic signed [SUM_W-1:0]   room_ext;

    // State register
    always_ff @(posedge clock or negedge rstn_in) begin
        if (!rstn_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (enabled_in) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_RUN;
            ST_RUN:  if (!enabled_in) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Round-robin search from rr_ptr; the exit cycle never grants
    always_comb begin
        int unsigned idx;
        logic [IDX_W-1:0] idx_v;
        grant     = 1'b0;
        grant_idx = '0;
        ready     = '0;
        idx       = 0;
        idx_v     = '0;
        if (state == ST_RUN && enabled_in && credits != '0) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                idx = 32'(rr_ptr) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                idx_v = IDX_W'(idx);
                if (!grant && bus.req_valid_in[idx_v]) begin
                    grant     = 1'b1;
                    grant_idx = idx_v;
                end
            end
            if (grant) ready = NUM_REQ'(1) << grant_idx;
        end
    end

    assign bus.req_ready_out = ready;

    // Net credit change for this cycle, signed and two bits wider than the counter
    always_comb begin
        ret          = bus.response_valid_in ? SUM_W'($signed(bus.response_credits_in)) : '0;
        room_ext     = $signed({2'b00, room_q});
        next_credits = $signed({2'b00, credits}) - $signed(SUM_W'(grant)) + ret;
    end

    // Credit, pointer, tag and command output registers
    always_ff @(posedge clock or negedge rstn_in) begin
        if (!rstn_in) begin
            credits               <= '0;
            room_q                <= '0;
            rr_ptr                <= '0;
            tag                   <= '0;
            credit_overflow_error <= 1'b0;
            bus.cmd_valid_out     <= 1'b0;
            bus.cmd_payload_out   <= '0;
            bus.cmd_tag_out       <= '0;
            bus.cmd_src_out       <= '0;
        end else begin
            bus.cmd_valid_out <= 1'b0;
            case (state)
                ST_LOAD: begin
                    credits <= room_in;
                    room_q  <= room_in;
                    tag     <= '0;
                end
                ST_RUN: begin
                    if (!enabled_in) begin
                        credits               <= '0;
                        credit_overflow_error <= 1'b0;
                        rr_ptr                <= '0;
                    end else begin
                        if (next_credits > room_ext) begin
                            credit_overflow_error <= 1'b1;
                            credits               <= room_q;
                        end else if (next_credits < 0) begin
                            credit_overflow_error <= 1'b1;
                            credits               <= '0;
                        end else begin
                            credits <= CREDIT_W'(next_credits);
                        end
                        if (grant) begin
                            bus.cmd_valid_out   <= 1'b1;
                            bus.cmd_payload_out <= bus.req_payload_in[32'(grant_idx)*PAYLOAD_W +: PAYLOAD_W];
                            bus.cmd_tag_out     <= tag;
                            bus.cmd_src_out     <= 3'(grant_idx);
                            tag                 <= tag + TAG_W'(1);
                            if (32'(grant_idx) == NUM_REQ - 1) begin
                                rr_ptr <= '0;
                            end else begin
                                rr_ptr <= grant_idx + IDX_W'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign credits_out = credits;

endmodule

// File: tb/tb_cmd_credit_arbiter.sv
// Scoreboard bench for cmd_credit_arbiter: directed stimulus pushes the
// expected command for every cycle it expects a grant; a negedge monitor pops
// and compares whenever cmd_valid_out is seen.
module tb_cmd_credit_arbiter;

    localparam int unsigned NUM_REQ   = 5;
    localparam int unsigned PAYLOAD_W = 128;
    localparam int unsigned CREDIT_W  = 8;

    typedef struct packed {
        logic [2:0]           src;
        logic [7:0]           tag;
        logic [PAYLOAD_W-1:0] payload;
    } exp_t;

    logic                clock = 1'b0;
    logic                rstn_in;
    logic                enabled_in;
    logic [CREDIT_W-1:0] room_in;
    logic [CREDIT_W-1:0] credits_out;
    logic                credit_overflow_error;

    cmd_credit_arbiter_if #(.NUM_REQ(NUM_REQ), .PAYLOAD_W(PAYLOAD_W)) bus ();

    cmd_credit_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .PAYLOAD_W(PAYLOAD_W),
        .CREDIT_W (CREDIT_W)
    ) dut (
        .clock                (clock),
        .rstn_in              (rstn_in),
        .enabled_in           (enabled_in),
        .room_in              (room_in),
        .bus                  (bus),
        .credits_out          (credits_out),
        .credit_overflow_error(credit_overflow_error)
    );

    always #5 clock = ~clock;

    exp_t                 q[$];
    int                   n_checks = 0;
    int                   n_pass   = 0;
    logic [7:0]           tag_exp  = 8'd0;
    logic [PAYLOAD_W-1:0] pay[NUM_REQ];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One clock cycle of stimulus; exp_src < 0 means no grant expected
    task automatic cyc(input string name, input logic [4:0] valid, input logic rv,
                       input logic [8:0] rc, input int exp_src);
        logic [4:0] er;
        @(posedge clock);
        #1;
        bus.req_valid_in        = valid;
        bus.response_valid_in   = rv;
        bus.response_credits_in = rc;
        #1;
        er = (exp_src < 0) ? 5'd0 : 5'(5'd1 << exp_src);
        chk({name, "_ready"}, 128'(bus.req_ready_out), 128'(er));
        if (exp_src >= 0) begin
            q.push_back({3'(exp_src), tag_exp, pay[exp_src]});
            tag_exp = tag_exp + 8'd1;
        end
    endtask

    task automatic idle();
        cyc("idle", 5'd0, 1'b0, 9'd0, -1);
    endtask

    task automatic chk_cred(input string name, input int cred, input logic err);
        chk({name, "_credits"}, 128'(credits_out), 128'(cred));
        chk({name, "_error"}, 128'(credit_overflow_error), 128'(err));
    endtask

    // Enable the job; returns at the start of the LOAD cycle
    task automatic start(input logic [7:0] room);
        @(posedge clock);
        #1;
        enabled_in = 1'b1;
        room_in    = room;
        bus.req_valid_in = 5'd0;
        bus.response_valid_in = 1'b0;
        @(posedge clock);
        #1;
        bus.req_valid_in = 5'h1F;
        #1;
        chk("load_ready", 128'(bus.req_ready_out), 128'd0);
        tag_exp = 8'd0;
    endtask

    // Drop enabled_in with every source requesting: no grant may happen
    task automatic stop(input string name);
        @(posedge clock);
        #1;
        enabled_in = 1'b0;
        bus.req_valid_in = 5'h1F;
        bus.response_valid_in = 1'b0;
        #1;
        chk({name, "_drop_ready"}, 128'(bus.req_ready_out), 128'd0);
        @(posedge clock);
        #2;
        chk_cred({name, "_after_drop"}, 0, 1'b0);
        chk({name, "_idle_ready"}, 128'(bus.req_ready_out), 128'd0);
        idle();
    endtask

    // Monitor: every presented command must match the head of the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (bus.cmd_valid_out === 1'b1) begin
                n_checks++;
                if (q.size() == 0) begin
                    $display("FAIL unexpected_cmd: got src %0d tag %0d, none expected",
                             bus.cmd_src_out, bus.cmd_tag_out);
                end else begin
                    e = q.pop_front();
                    if (bus.cmd_src_out === e.src && bus.cmd_tag_out === e.tag &&
                        bus.cmd_payload_out === e.payload) begin
                        n_pass++;
                    end else begin
                        $display("FAIL cmd: got src %0d tag %0d payload %0h expected src %0d tag %0d payload %0h",
                                 bus.cmd_src_out, bus.cmd_tag_out, bus.cmd_payload_out,
                                 e.src, e.tag, e.payload);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset held with random inputs
        rstn_in    = 1'b0;
        enabled_in = 1'b1;
        room_in    = 8'($urandom);
        bus.req_valid_in        = 5'($urandom);
        bus.req_payload_in      = {$urandom, $urandom, $urandom, $urandom, $urandom,
                                   $urandom, $urandom, $urandom, $urandom, $urandom,
                                   $urandom, $urandom, $urandom, $urandom, $urandom,
                                   $urandom, $urandom, $urandom, $urandom, $urandom};
        bus.response_valid_in   = 1'b1;
        bus.response_credits_in = 9'($urandom);
        repeat (3) @(posedge clock);
        #1;
        chk("rst_cmd_valid", 128'(bus.cmd_valid_out), 128'd0);
        chk("rst_payload", bus.cmd_payload_out, 128'd0);
        chk("rst_tag", 128'(bus.cmd_tag_out), 128'd0);
        chk("rst_src", 128'(bus.cmd_src_out), 128'd0);
        chk("rst_ready", 128'(bus.req_ready_out), 128'd0);
        chk_cred("rst", 0, 1'b0);

        for (int i = 0; i < int'(NUM_REQ); i++) begin
            pay[i] = {32'(i + 1) * 32'h0101_0101, 32'hCAFE_0000 | 32'(i), ~32'(i), 32'h1234_5678 + 32'(i)};
            bus.req_payload_in[i*PAYLOAD_W +: PAYLOAD_W] = pay[i];
        end
        enabled_in = 1'b0;
        bus.response_valid_in = 1'b0;
        bus.response_credits_in = 9'd0;
        rstn_in = 1'b1;
        cyc("idle_rst", 5'h1F, 1'b0, 9'd0, -1);
        cyc("idle_rst", 5'h1F, 1'b0, 9'd0, -1);
        chk_cred("idle_rst", 0, 1'b0);

        // Single source
        start(8'd8);
        repeat (3) cyc("single", 5'b00010, 1'b0, 9'd0, 1);
        idle();
        chk_cred("single", 5, 1'b0);
        stop("single");

        // Fairness with all sources requesting
        start(8'd64);
        for (int k = 0; k < 10; k++) cyc("fair", 5'h1F, 1'b0, 9'd0, k % 5);
        idle();
        chk_cred("fair", 54, 1'b0);
        stop("fair");

        // Exhaustion and a single returned credit
        start(8'd2);
        cyc("exh", 5'b00100, 1'b0, 9'd0, 2);
        cyc("exh", 5'b00100, 1'b0, 9'd0, 2);
        cyc("exh_empty", 5'b00100, 1'b0, 9'd0, -1);
        cyc("exh_ret", 5'b00100, 1'b1, 9'd1, -1);
        cyc("exh_regrant", 5'b00100, 1'b0, 9'd0, 2);
        chk_cred("exh_ret_visible", 1, 1'b0);
        cyc("exh_empty2", 5'b00100, 1'b0, 9'd0, -1);
        idle();
        chk_cred("exh", 0, 1'b0);
        stop("exh");

        // Simultaneous issue and return, then tag wrap
        start(8'd64);
        cyc("simul_pre", 5'b00001, 1'b0, 9'd0, 0);
        cyc("simul", 5'b00010, 1'b1, 9'd1, 1);
        cyc("wrap", 5'h1F, 1'b1, 9'd1, 2);
        chk_cred("simul", 63, 1'b0);
        for (int k = 1; k < 300; k++) cyc("wrap", 5'h1F, 1'b1, 9'd1, (2 + k) % 5);
        idle();
        chk_cred("wrap", 63, 1'b0);
        chk("wrap_last_tag", 128'(bus.cmd_tag_out), 128'd45);
        stop("wrap");

        // Overflow, underflow, issue after error, abort clears error
        start(8'd4);
        cyc("ovf", 5'd0, 1'b1, 9'd1, -1);
        idle();
        chk_cred("ovf", 4, 1'b1);
        cyc("unf", 5'd0, 1'b1, 9'h1F8, -1);
        idle();
        chk_cred("unf", 0, 1'b1);
        cyc("refill", 5'd0, 1'b1, 9'd3, -1);
        cyc("post_err", 5'h1F, 1'b0, 9'd0, 0);
        cyc("post_err", 5'h1F, 1'b0, 9'd0, 1);
        idle();
        chk_cred("post_err", 1, 1'b1);
        stop("abort");

        // Restart: pointer and tag start over
        start(8'd8);
        cyc("restart", 5'h1F, 1'b0, 9'd0, 0);
        idle();
        stop("restart");

        // Asynchronous reset during a grant cycle drops the pending command
        start(8'd8);
        cyc("midrst", 5'h1F, 1'b0, 9'd0, 0);
        #1;
        rstn_in = 1'b0;
        void'(q.pop_back());
        #1;
        chk("midrst_ready", 128'(bus.req_ready_out), 128'd0);
        chk_cred("midrst", 0, 1'b0);
        @(posedge clock);
        #1;
        chk("midrst_cmd_valid", 128'(bus.cmd_valid_out), 128'd0);
        enabled_in = 1'b0;
        bus.req_valid_in = 5'd0;
        rstn_in = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("queue_empty", 128'(q.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cmd_credit_arbiter.md
# cmd_credit_arbiter

Round-robin command arbiter that shares the single PSL command port among the AFU's command sources: WED, read, write, prefetch-read and prefetch-write. It tracks PSL command credits, loading them from the job's room value and returning them from command responses. It issues at most one command per cycle with a wrapping 8-bit tag. It sits between the per-source command buffers and the command output register inside the AFU control path.

## Interface
Parameters:
- NUM_REQ, 5: number of requesters. Index 0 is WED, then read, write, prefetch-read, prefetch-write.
- PAYLOAD_W, 128: command payload width per requester (command, address, size, cu id).
- CREDIT_W, 8: width of the credit counter and of room_in.

Ports:
- clock  in  1: single clock; all logic on its rising edge.
- rstn_in  in  1: reset, asynchronous, active-low.
- enabled_in  in  1: job running. Rising edge loads credits; falling edge returns the block to IDLE.
- room_in  in  CREDIT_W: PSL command room, sampled in LOAD.
- req_valid_in  in  NUM_REQ: per-requester command available.
- req_payload_in  in  NUM_REQ*PAYLOAD_W: requester i occupies bits [i*PAYLOAD_W +: PAYLOAD_W].
- req_ready_out  out  NUM_REQ: one-hot pop strobe. A transfer occurs when valid & ready.
- response_valid_in  in  1: PSL response strobe.
- response_credits_in  in  9: signed credit return, valid with response_valid_in.
- cmd_valid_out  out  1: registered command strobe to the PSL.
- cmd_payload_out  out  PAYLOAD_W: registered payload of the granted command.
- cmd_tag_out  out  8: registered tag.
- cmd_src_out  out  3: registered index of the granted requester.
- credits_out  out  CREDIT_W: current available credits.
- credit_overflow_error  out  1: sticky error flag.

## Operation
State machine:
- IDLE -> LOAD when enabled_in=1.
- LOAD lasts one cycle: credits <= room_in, room_q <= room_in, tag <= 0, then RUN.
- RUN -> IDLE on the first cycle enabled_in=0. Exit clears credits, error and the RR pointer; no issue occurs in that cycle.

Arbitration (RUN only; req_ready_out=0 in IDLE and LOAD):
- The arbiter is eligible when credits!=0.
- Search starts at index rr_ptr and wraps modulo NUM_REQ. The first i with req_valid_in[i]=1 is granted and req_ready_out[i]=1 combinationally.
- After a grant, rr_ptr <= (i+1) mod NUM_REQ. rr_ptr is unchanged when nothing is granted.
- On a grant, the next cycle has cmd_valid_out=1, payload/src from i and cmd_tag_out=tag. Then tag <= tag+1, wrapping 255 -> 0.

Credit arithmetic (RUN):
- Let issue = any grant, and ret = response_credits_in when response_valid_in else 0.
- next = credits - issue + ret, computed sign-extended to CREDIT_W+2 bits.
- If next > room_q: credit_overflow_error <= 1 and credits <= room_q.
- If next < 0: same error, credits <= 0.
- Otherwise credits <= next.
- A simultaneous issue and return nets out in the same cycle.
- A return that arrives with credits=0 makes the arbiter eligible in the following cycle, not the same cycle.
- Responses in IDLE or LOAD are ignored.

Error:
- credit_overflow_error is sticky until reset or exit from RUN. Issue continues after the error.

## Timing
- Reset values: all outputs 0. State IDLE, credits 0, room_q 0, rr_ptr 0, tag 0.
- Reset asserted mid-operation clears everything immediately (asynchronous). Any command registered in that cycle is dropped.
- Latency: enabled_in rise -> LOAD one cycle later -> first possible grant two cycles after the rise.
- Grant -> cmd_valid_out: 1 cycle. Throughput is 1 command/cycle while credits>0.
- Credit update is visible on credits_out one cycle after the grant or response.
- req_ready_out depends on req_valid_in, credits and rr_ptr only. It has no dependency on response inputs.

## Test plan
- Reset: hold rstn_in=0, drive random inputs -> all outputs 0. Release with enabled_in=0 -> state stays IDLE, req_ready_out=0.
- Single source: room_in=8, enabled_in=1, req_valid_in=5'b00010 for 3 cycles -> 3 commands with src=1 and tags 0,1,2; credits_out reaches 5.
- Fairness: room_in=64, all five valid for 10 cycles -> src sequence 0,1,2,3,4,0,1,2,3,4.
- Exhaustion: room_in=2, continuous requests -> exactly 2 issues, then ready=0. One response with credits=+1 -> exactly one more issue, starting the cycle after the credit becomes visible.
- Simultaneous events and wrap: issue in the same cycle as a +1 return -> credits unchanged. 300 issues with room_in=64 and matching returns -> tag wraps 255 -> 0.
- Overflow and abort: room_in=4, no issues, response credits=+1 -> credits_out=4 and credit_overflow_error=1. Dropping enabled_in mid-stream -> IDLE next cycle, credits 0, error cleared, no cmd_valid_out after the drop cycle.
